intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter NCH, default 8, number of interrupt channels (1..32).
REQ-002 Parameter IDW, default 3, width of channel index (at least clog2(NCH), minimum 1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 irq_in  input  NCH  raw external interrupt lines, asynchronous to clk.
REQ-006 csr_meie  input  1  global machine external-interrupt enable from the CSR file.
REQ-007 g_interrupt  output  1  registered interrupt request to the EX stage.
REQ-008 int_id  output  IDW  registered index of the requesting channel; valid while g_interrupt=1.
REQ-009 int_claim  input  1  one-cycle pulse: trap taken for int_id.
REQ-010 int_complete  input  1  one-cycle pulse: handler finished the channel in int_cmpl_id.
REQ-011 int_cmpl_id  input  IDW  channel being completed.
REQ-012 cfg_we  input  1  configuration write strobe.
REQ-013 cfg_wadr  input  2  configuration write register select.
REQ-014 cfg_wdata  input  32  configuration write data; bits NCH-1:0 used.
REQ-015 cfg_radr  input  2  configuration read register select.
REQ-016 cfg_rdata  output  32  registered read data, upper bits zero.

Function
REQ-017 Each irq_in bit SHALL pass a 2-flop synchronizer (irq_s), plus one history flop (irq_d).
REQ-018 Register map: 0 ENABLE (RW); 1 EDGE mode, 1=edge, 0=level (RW); 2 PENDING (R, write-1-clear, edge channels only); 3 IN_SERVICE (R, writes ignored).
REQ-019 Edge channel: pending set when irq_s & ~irq_d; cleared by claim or PENDING W1C; a set in the same cycle wins over any clear.
REQ-020 Level channel: pending equals irq_s each cycle; claim and W1C have no effect on it.
REQ-021 eligible = pending & ENABLE & ~IN_SERVICE.
REQ-022 The next value of g_interrupt SHALL be csr_meie & |eligible.
REQ-023 The next value of int_id SHALL be the lowest-index eligible channel (fixed priority; 0 is highest).
REQ-024 int_id SHALL hold its value when nothing is eligible.
REQ-025 Latency from an irq_in edge to g_interrupt=1 SHALL be 4 cycles: 2 synchronizer, 1 pending, 1 output register.
REQ-026 int_claim while g_interrupt=1 SHALL set IN_SERVICE[int_id] and clear an edge pending bit.
REQ-027 The cycle after a claim, g_interrupt SHALL drop, or show the next eligible channel.
REQ-028 int_claim while g_interrupt=0 SHALL be ignored.
REQ-029 int_complete SHALL clear IN_SERVICE[int_cmpl_id]; an index >= NCH, or a channel not in service, is a no-op.
REQ-030 Claim and complete in the same cycle SHALL both take effect; a claimed channel is never eligible, so they cannot target the same channel.
REQ-031 Clearing ENABLE or csr_meie SHALL keep pending bits and drop g_interrupt on the next cycle.
REQ-032 A config write and an internal update to the same bit in the same cycle: a pending set beats W1C; ENABLE/EDGE writes take effect the next cycle.
REQ-033 Changing a channel from level to edge mode SHALL clear its pending bit.
REQ-034 cfg_rdata SHALL be valid one cycle after cfg_radr is presented.

Reset
REQ-035 While rst_n=0, all of the following SHALL be 0: synchronizers, irq_d, PENDING, ENABLE, EDGE, IN_SERVICE, g_interrupt, int_id, cfg_rdata.
REQ-036 Reset asserted mid-service SHALL drop all in-service state; no complete is needed afterwards.

Structure
REQ-037 Register-select constants (ENABLE, EDGE, PENDING, IN_SERVICE) SHALL live in a shared package, shared with the CSR and DMA decode logic.
REQ-038 One sub-module, intr_sync (NCH-wide 2-flop synchronizer, async reset), SHALL be instantiated.
REQ-039 intr_ctrl SHALL replace the single-line interrupter in cpu_top; csr_meie SHALL be wired unchanged.

Verification
REQ-040 NCH=8; ENABLE=0x05, EDGE=0x01, csr_meie=1; pulse irq_in[0] -> g_interrupt=1, int_id=0 exactly 4 cycles later; claim -> IN_SERVICE=0x01, PENDING[0]=0.
REQ-041 Level irq_in[2] held high while channel 0 is in service -> int_id=2; claim -> no new request from 2 until complete, then re-request if the line is still high.
REQ-042 Edges on channels 0 and 2 in the same cycle -> int_id=0 first; after claim of 0, int_id=2 on the next cycle.
REQ-043 New edge on channel 0 in the same cycle as a PENDING W1C of 0x01 -> PENDING[0] remains 1.
REQ-044 Pending channel 2 with csr_meie=0 -> g_interrupt=0; set csr_meie=1 -> g_interrupt=1 one cycle later.
REQ-045 Assert rst_n=0 with IN_SERVICE=0x05 -> all registers 0 immediately; int_claim pulsed during reset is ignored.

Source files
------------

// File: rtl/intr_ctrl_pkg.sv
// Shared register-select constants for the interrupt controller config port.
// The CSR and DMA decode logic import the same names so every block agrees on
// which select value means which register.
package intr_ctrl_pkg;

    localparam int CFG_AW = 2;
    localparam int CFG_DW = 32;

    localparam logic [CFG_AW-1:0] REG_ENABLE     = 2'd0;
    localparam logic [CFG_AW-1:0] REG_EDGE       = 2'd1;
    localparam logic [CFG_AW-1:0] REG_PENDING    = 2'd2;
    localparam logic [CFG_AW-1:0] REG_IN_SERVICE = 2'd3;

endpackage

// File: rtl/intr_sync.sv
// W-bit two-flop synchronizer bringing asynchronous interrupt lines into clk.
module intr_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; only q is safe to use downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Fixed-priority external interrupt controller. Synchronizes the raw lines,
// tracks pending (edge or level) and in-service state per channel, and
// presents the lowest-index eligible channel to the EX stage.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int NCH = 8,
    parameter int IDW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    irq_in,
    input  logic              csr_meie,
    output logic              g_interrupt,
    output logic [IDW-1:0]    int_id,
    input  logic              int_claim,
    input  logic              int_complete,
    input  logic [IDW-1:0]    int_cmpl_id,
    input  logic              cfg_we,
    input  logic [CFG_AW-1:0] cfg_wadr,
    input  logic [CFG_DW-1:0] cfg_wdata,
    input  logic [CFG_AW-1:0] cfg_radr,
    output logic [CFG_DW-1:0] cfg_rdata
);

    logic [NCH-1:0] irq_s;
    logic [NCH-1:0] irq_d;
    logic [NCH-1:0] enable;
    logic [NCH-1:0] edge_mode;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] in_service;

    logic [NCH-1:0] wdata_ch;
    logic           wr_enable;
    logic           wr_edge;
    logic           wr_pending;
    logic           claim_ok;
    logic [NCH-1:0] claim_mask;
    logic [NCH-1:0] cmpl_mask;
    logic [NCH-1:0] edge_set;
    logic [NCH-1:0] w1c_mask;
    logic [NCH-1:0] to_edge;
    logic [NCH-1:0] pending_nxt;
    logic [NCH-1:0] in_service_nxt;
    logic [NCH-1:0] eligible;
    logic           any_eligible;
    logic [IDW-1:0] id_nxt;
    logic [CFG_DW-1:0] rd_mux;

    // Only the low NCH bits of write data carry meaning.
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata;

    intr_sync #(.W(NCH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (irq_in),
        .q     (irq_s)
    );

    // History flop for rising-edge detection on the synchronized lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_d <= '0;
        else        irq_d <= irq_s;
    end

    assign wdata_ch   = cfg_wdata[NCH-1:0];
    assign wr_enable  = cfg_we && (cfg_wadr == REG_ENABLE);
    assign wr_edge    = cfg_we && (cfg_wadr == REG_EDGE);
    assign wr_pending = cfg_we && (cfg_wadr == REG_PENDING);

    // A claim only counts while a request is actually being presented.
    assign claim_ok = int_claim && g_interrupt;

    // One-hot decode of the claimed and completed channels; an out-of-range
    // completion index matches nothing and so is a no-op.
    always_comb begin
        claim_mask = '0;
        cmpl_mask  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (claim_ok && (int_id == IDW'(i)))          claim_mask[i] = 1'b1;
            if (int_complete && (int_cmpl_id == IDW'(i))) cmpl_mask[i]  = 1'b1;
        end
    end

    // Edge channels: set beats claim/W1C. Level channels follow the line.
    // A channel switched from level to edge starts with a clean pending bit.
    assign edge_set    = irq_s & ~irq_d & edge_mode;
    assign w1c_mask    = wr_pending ? wdata_ch : '0;
    assign to_edge     = wr_edge ? (wdata_ch & ~edge_mode) : '0;
    assign pending_nxt = ((edge_mode & ((pending & ~claim_mask & ~w1c_mask) | edge_set))
                         | (~edge_mode & irq_s)) & ~to_edge;

    // Completion retires the old service bit, a claim sets a new one.
    assign in_service_nxt = (in_service & ~cmpl_mask) | claim_mask;

    // The channel being claimed right now must not be re-presented next cycle.
    assign eligible     = pending & enable & ~in_service & ~claim_mask;
    assign any_eligible = |eligible;

    // Fixed priority: lowest index wins; hold the last id when idle.
    always_comb begin
        id_nxt = int_id;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (eligible[i]) id_nxt = IDW'(i);
        end
    end

    // Software-visible configuration; writes land on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= '0;
            edge_mode <= '0;
        end else begin
            if (wr_enable) enable    <= wdata_ch;
            if (wr_edge)   edge_mode <= wdata_ch;
        end
    end

    // Pending and in-service state per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            in_service <= '0;
        end else begin
            pending    <= pending_nxt;
            in_service <= in_service_nxt;
        end
    end

    // Registered request and channel index toward the EX stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_interrupt <= 1'b0;
            int_id      <= '0;
        end else begin
            g_interrupt <= csr_meie && any_eligible;
            int_id      <= id_nxt;
        end
    end

    // Read-side register select, zero-extended to the bus width.
    always_comb begin
        rd_mux = '0;
        case (cfg_radr)
            REG_ENABLE:     rd_mux[NCH-1:0] = enable;
            REG_EDGE:       rd_mux[NCH-1:0] = edge_mode;
            REG_PENDING:    rd_mux[NCH-1:0] = pending;
            REG_IN_SERVICE: rd_mux[NCH-1:0] = in_service;
        endcase
    end

    // Read data appears one cycle after the select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_rdata <= '0;
        else        cfg_rdata <= rd_mux;
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus a randomized run
// checked against a per-channel behavioural model.
module tb_intr_ctrl;

    localparam int NCH = 8;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] irq_in;
    logic           csr_meie;
    logic           g_interrupt;
    logic [IDW-1:0] int_id;
    logic           int_claim;
    logic           int_complete;
    logic [IDW-1:0] int_cmpl_id;
    logic           cfg_we;
    logic [1:0]     cfg_wadr;
    logic [31:0]    cfg_wdata;
    logic [1:0]     cfg_radr;
    logic [31:0]    cfg_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    // model state
    bit [7:0]  m_s1, m_s, m_d, m_pend, m_en, m_edge, m_isvc;
    bit        m_gi;
    int        m_id;
    bit [31:0] m_rd;

    intr_ctrl #(.NCH(NCH), .IDW(IDW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .csr_meie     (csr_meie),
        .g_interrupt  (g_interrupt),
        .int_id       (int_id),
        .int_claim    (int_claim),
        .int_complete (int_complete),
        .int_cmpl_id  (int_cmpl_id),
        .cfg_we       (cfg_we),
        .cfg_wadr     (cfg_wadr),
        .cfg_wdata    (cfg_wdata),
        .cfg_radr     (cfg_radr),
        .cfg_rdata    (cfg_rdata)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = 0; m_s = 0; m_d = 0; m_pend = 0; m_en = 0; m_edge = 0; m_isvc = 0;
        m_gi = 0; m_id = 0; m_rd = 0;
    endtask

    // One rising edge of the behavioural model, from the inputs now applied.
    task automatic model_clock();
        int claim_ch, cmpl_ch, best;
        bit [7:0] np, ni;
        bit [31:0] rd;
        claim_ch = (int_claim && m_gi) ? m_id : -1;
        cmpl_ch  = int_complete ? int'(int_cmpl_id) : -1;
        best = -1;
        np = 0;
        ni = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_edge[ch]) begin
                np[ch] = m_pend[ch];
                if (claim_ch == ch) np[ch] = 0;
                if (cfg_we && cfg_wadr == 2'd2 && cfg_wdata[ch]) np[ch] = 0;
                if (m_s[ch] && !m_d[ch]) np[ch] = 1;
            end else begin
                np[ch] = m_s[ch];
                if (cfg_we && cfg_wadr == 2'd1 && cfg_wdata[ch]) np[ch] = 0;
            end
            ni[ch] = m_isvc[ch];
            if (cmpl_ch == ch)  ni[ch] = 0;
            if (claim_ch == ch) ni[ch] = 1;
            if (best < 0 && m_pend[ch] && m_en[ch] && !m_isvc[ch] && claim_ch != ch)
                best = ch;
        end
        case (cfg_radr)
            2'd0:    rd = {24'd0, m_en};
            2'd1:    rd = {24'd0, m_edge};
            2'd2:    rd = {24'd0, m_pend};
            default: rd = {24'd0, m_isvc};
        endcase
        m_gi = csr_meie && (best >= 0);
        if (best >= 0) m_id = best;
        m_pend = np;
        m_isvc = ni;
        m_rd   = rd;
        if (cfg_we && cfg_wadr == 2'd0) m_en   = cfg_wdata[7:0];
        if (cfg_we && cfg_wadr == 2'd1) m_edge = cfg_wdata[7:0];
        m_d  = m_s;
        m_s  = m_s1;
        m_s1 = irq_in;
    endtask

    // Advance one clock; inputs change only on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_clock();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        irq_in = '0; csr_meie = 1'b0; int_claim = 1'b0; int_complete = 1'b0;
        int_cmpl_id = '0; cfg_we = 1'b0; cfg_wadr = '0; cfg_wdata = '0; cfg_radr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] adr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_wadr = adr; cfg_wdata = data;
        cyc();
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [1:0] adr, output logic [31:0] val);
        cfg_radr = adr;
        cyc();
        val = cfg_rdata;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        irq_in = '1;
        csr_meie = 1'b1;
        model_reset();
        #1;
        n_chk++; if (g_interrupt !== 1'b0) $display("FAIL reset_g: got %0b want 0", g_interrupt); else n_pass++;
        cyc(); cyc(); cyc();
        n_chk++; if (int_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", int_id); else n_pass++;
        n_chk++; if (cfg_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", cfg_rdata); else n_pass++;
        n_chk++; if (g_interrupt !== 1'b0) $display("FAIL reset_g_held: got %0b want 0", g_interrupt); else n_pass++;
        rst_n = 1'b1;
        irq_in = '0;
    endtask

    task automatic test_edge_latency();
        logic [31:0] v;
        do_reset();
        cfg_write(2'd0, 32'h05);
        cfg_write(2'd1, 32'h01);
        csr_meie = 1'b1;
        cyc(); cyc(); cyc();
        irq_in[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            irq_in[0] = 1'b0;
            if (k < 4) begin
                n_chk++; if (g_interrupt !== 1'b0) $display("FAIL latency_early c%0d: got %0b want 0", k, g_interrupt); else n_pass++;
            end
        end
        n_chk++; if (g_interrupt !== 1'b1 || int_id !== 3'd0)
            $display("FAIL latency_4: got g=%0b id=%0d want g=1 id=0", g_interrupt, int_id); else n_pass++;
        int_claim = 1'b1;
        cyc();
        int_claim = 1'b0;
        n_chk++; if (g_interrupt !== 1'b0) $display("FAIL claim_drop: got %0b want 0", g_interrupt); else n_pass++;
        cfg_read(2'd3, v);
        n_chk++; if (v !== 32'h01) $display("FAIL claim_insvc: got %h want 01", v); else n_pass++;
        cfg_read(2'd2, v);
        n_chk++; if (v !== 32'h00) $display("FAIL claim_pend: got %h want 00", v); else n_pass++;
    endtask

    // Continues from test_edge_latency: channel 0 is in service.
    task automatic test_level_in_service();
        irq_in[2] = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        n_chk++; if (g_interrupt !== 1'b1 || int_id !== 3'd2)
            $display("FAIL level_req: got g=%0b id=%0d want g=1 id=2", g_interrupt, int_id); else n_pass++;
        int_claim = 1'b1;
        cyc();
        int_claim = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (g_interrupt !== 1'b0) $display("FAIL level_blocked c%0d: got %0b want 0", k, g_interrupt); else n_pass++;
            cyc();
        end
        int_complete = 1'b1; int_cmpl_id = 3'd2;
        cyc();
        int_complete = 1'b0;
        cyc();
        n_chk++; if (g_interrupt !== 1'b1 || int_id !== 3'd2)
            $display("FAIL level_rereq: got g=%0b id=%0d want g=1 id=2", g_interrupt, int_id); else n_pass++;
        irq_in[2] = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg_write(2'd0, 32'h05);
        cfg_write(2'd1, 32'h05);
        csr_meie = 1'b1;
        irq_in = 8'h05;
        cyc();
        irq_in = 8'h00;
        cyc(); cyc(); cyc();
        n_chk++; if (g_interrupt !== 1'b1 || int_id !== 3'd0)
            $display("FAIL b2b_first: got g=%0b id=%0d want g=1 id=0", g_interrupt, int_id); else n_pass++;
        int_claim = 1'b1;
        cyc();
        int_claim = 1'b0;
        n_chk++; if (g_interrupt !== 1'b1 || int_id !== 3'd2)
            $display("FAIL b2b_second: got g=%0b id=%0d want g=1 id=2", g_interrupt, int_id); else n_pass++;
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        do_reset();
        cfg_write(2'd1, 32'h01);
        irq_in[0] = 1'b1;
        cyc();
        irq_in[0] = 1'b0;
        cyc(); cyc(); cyc();
        cfg_read(2'd2, v);
        n_chk++; if (v !== 32'h01) $display("FAIL w1c_pre: got %h want 01", v); else n_pass++;
        irq_in[0] = 1'b1;
        cyc();
        irq_in[0] = 1'b0;
        cyc();
        cfg_we = 1'b1; cfg_wadr = 2'd2; cfg_wdata = 32'h01;
        cyc();
        cfg_we = 1'b0; cfg_wdata = '0;
        cfg_read(2'd2, v);
        n_chk++; if (v !== 32'h01) $display("FAIL w1c_race: got %h want 01", v); else n_pass++;
        cfg_write(2'd2, 32'h01);
        cfg_read(2'd2, v);
        n_chk++; if (v !== 32'h00) $display("FAIL w1c_clear: got %h want 00", v); else n_pass++;
    endtask

    task automatic test_meie();
        do_reset();
        cfg_write(2'd0, 32'h04);
        csr_meie = 1'b0;
        irq_in[2] = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        n_chk++; if (g_interrupt !== 1'b0) $display("FAIL meie_off: got %0b want 0", g_interrupt); else n_pass++;
        csr_meie = 1'b1;
        cyc();
        n_chk++; if (g_interrupt !== 1'b1 || int_id !== 3'd2)
            $display("FAIL meie_on: got g=%0b id=%0d want g=1 id=2", g_interrupt, int_id); else n_pass++;
        irq_in[2] = 1'b0;
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] v;
        do_reset();
        cfg_write(2'd0, 32'h05);
        cfg_write(2'd1, 32'h05);
        csr_meie = 1'b1;
        irq_in = 8'h05;
        cyc();
        irq_in = 8'h00;
        cyc(); cyc(); cyc();
        int_claim = 1'b1;
        cyc();
        cyc();
        int_claim = 1'b0;
        cfg_read(2'd3, v);
        n_chk++; if (v !== 32'h05) $display("FAIL mid_insvc: got %h want 05", v); else n_pass++;
        rst_n = 1'b0;
        int_claim = 1'b1;
        model_reset();
        #1;
        n_chk++; if (g_interrupt !== 1'b0 || int_id !== 3'd0 || cfg_rdata !== 32'd0)
            $display("FAIL mid_rst_now: got g=%0b id=%0d rd=%h want 0", g_interrupt, int_id, cfg_rdata); else n_pass++;
        cyc(); cyc();
        n_chk++; if (g_interrupt !== 1'b0 || cfg_rdata !== 32'd0)
            $display("FAIL mid_rst_claim: got g=%0b rd=%h want 0", g_interrupt, cfg_rdata); else n_pass++;
        rst_n = 1'b1;
        int_claim = 1'b0;
        cfg_read(2'd3, v);
        n_chk++; if (v !== 32'h00) $display("FAIL mid_post_insvc: got %h want 00", v); else n_pass++;
        cfg_read(2'd0, v);
        n_chk++; if (v !== 32'h00) $display("FAIL mid_post_enable: got %h want 00", v); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        csr_meie = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < NCH; b++)
                if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(0, 9) == 0) csr_meie = ~csr_meie;
            cfg_we      = ($urandom_range(0, 7) == 0);
            cfg_wadr    = 2'($urandom_range(0, 3));
            cfg_wdata   = $urandom;
            cfg_radr    = 2'($urandom_range(0, 3));
            int_claim   = (m_gi && $urandom_range(0, 1) == 0) || ($urandom_range(0, 7) == 0);
            int_complete = ($urandom_range(0, 5) == 0);
            int_cmpl_id = 3'($urandom_range(0, 7));
            cyc();
            n_chk++;
            if (g_interrupt !== m_gi || int_id !== 3'(m_id) || cfg_rdata !== m_rd)
                $display("FAIL rand c%0d: got g=%0b id=%0d rd=%h want g=%0b id=%0d rd=%h",
                         n, g_interrupt, int_id, cfg_rdata, m_gi, m_id, m_rd);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_edge_latency();
        test_level_in_service();
        test_back_to_back();
        test_w1c_race();
        test_meie();
        test_reset_mid_service();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
